// File: rtl/lcd_char_writer_if.sv
// ============================================================================
// Module   : lcd_char_writer_if
// Purpose  : Byte request handshake between a producer (master) and the
//            LCD character writer (slave).
// Signals  : in_valid  master->slave  byte request
//            in_rs     master->slave  0 = command, 1 = DDRAM data
//            in_data   master->slave  byte to send
//            in_ready  slave->master  writer can accept this cycle
//            done      slave->master  one-cycle pulse when a byte has fully
//                                     completed, including its exec wait
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface lcd_char_writer_if;
   logic       in_valid;
   logic       in_rs;
   logic [7:0] in_data;
   logic       in_ready;
   logic       done;

   modport master (output in_valid, output in_rs, output in_data,
                   input  in_ready, input  done);
   modport slave  (input  in_valid, input  in_rs, input  in_data,
                   output in_ready, output done);
endinterface

`default_nettype wire

// File: rtl/lcd_char_writer.sv
// ============================================================================
// Module   : lcd_char_writer
// Purpose  : Sends one command/data byte to an HD44780 in 4-bit mode as two
//            nibbles (high first) with E setup/pulse/gap timing, then holds
//            off for the controller's execution time before accepting the
//            next byte.
// Ports    : clk        50 MHz system clock
//            reset      synchronous, active-high
//            init_done  from the init sequencer; gates new accepts only
//            bus        byte handshake (slave side of lcd_char_writer_if)
//            SF_D       LCD data nibble
//            LCD_E      LCD enable
//            LCD_RS     LCD register select
//            LCD_RW     constant 0 (write only)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_char_writer #(
   parameter int C_SETUP      = 2,
   parameter int C_PULSE      = 12,
   parameter int C_NIBBLE_GAP = 50,
   parameter int C_CMD_WAIT   = 2000,
   parameter int C_CLEAR_WAIT = 82000,
   parameter int CNT_W        = 20
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         init_done,
   lcd_char_writer_if.slave  bus,
   output logic [3:0]        SF_D,
   output logic              LCD_E,
   output logic              LCD_RS,
   output logic              LCD_RW
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HI_SETUP = 3'd1,
      S_HI_PULSE = 3'd2,
      S_GAP      = 3'd3,
      S_LO_SETUP = 3'd4,
      S_LO_PULSE = 3'd5,
      S_WAIT     = 3'd6
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       lo_nib_q;     // low nibble kept for the second transfer
   logic             long_wait_q;  // clear/home command: long execution time
   logic [3:0]       sf_d_q;
   logic             e_q;
   logic             rs_q;
   logic             done_q;

   logic [CNT_W-1:0] limit_d;
   logic             last_d;
   logic             ready_d;
   logic             is_clear_d;

   assign ready_d = (state_q == S_IDLE) & init_done & ~reset;

   // Clear (0x01) and home (0x02/0x03) are the only slow commands.
   assign is_clear_d = ~bus.in_rs & (bus.in_data[7:2] == 6'd0)
                                  & (bus.in_data[1:0] != 2'd0);

   // Length in cycles of the current state.
   always_comb begin
      limit_d = CNT_W'(C_SETUP);
      case (state_q)
         S_HI_SETUP, S_LO_SETUP: limit_d = CNT_W'(C_SETUP);
         S_HI_PULSE, S_LO_PULSE: limit_d = CNT_W'(C_PULSE);
         S_GAP:                  limit_d = CNT_W'(C_NIBBLE_GAP);
         S_WAIT:                 limit_d = long_wait_q ? CNT_W'(C_CLEAR_WAIT)
                                                       : CNT_W'(C_CMD_WAIT);
         default:                limit_d = CNT_W'(C_SETUP);
      endcase
   end

   assign last_d = (cnt_q == (limit_d - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lo_nib_q    <= 4'd0;
         long_wait_q <= 1'b0;
         sf_d_q      <= 4'd0;
         e_q         <= 1'b0;
         rs_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == S_IDLE) begin
            cnt_q <= '0;
            if (bus.in_valid && ready_d) begin
               // Bus outputs are loaded here so SF_D/RS are already valid
               // in the first HI_SETUP cycle.
               lo_nib_q    <= bus.in_data[3:0];
               long_wait_q <= is_clear_d;
               sf_d_q      <= bus.in_data[7:4];
               rs_q        <= bus.in_rs;
               e_q         <= 1'b0;
               state_q     <= S_HI_SETUP;
            end
         end else if (!last_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= '0;
            case (state_q)
               S_HI_SETUP: begin
                  state_q <= S_HI_PULSE;
                  e_q     <= 1'b1;
               end
               S_HI_PULSE: begin
                  state_q <= S_GAP;
                  e_q     <= 1'b0;
               end
               S_GAP: begin
                  state_q <= S_LO_SETUP;
                  sf_d_q  <= lo_nib_q;
               end
               S_LO_SETUP: begin
                  state_q <= S_LO_PULSE;
                  e_q     <= 1'b1;
               end
               S_LO_PULSE: begin
                  state_q <= S_WAIT;
                  e_q     <= 1'b0;
               end
               S_WAIT: begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
               default: begin
                  state_q <= S_IDLE;
                  e_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.in_ready = ready_d;
   assign bus.done     = done_q;
   assign SF_D         = sf_d_q;
   assign LCD_E        = e_q;
   assign LCD_RS       = rs_q;
   assign LCD_RW       = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_char_writer.sv
// ============================================================================
// Module   : tb_lcd_char_writer
// Purpose  : Self-checking bench for lcd_char_writer. A timeline model
//            predicts every output in every cycle from the byte accepted and
//            the number of cycles since its accept; directed steps cover the
//            handshake, clear/home wait, back-to-back, init_done gating and
//            mid-transfer reset, followed by randomized bytes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_char_writer;

   localparam int P_SETUP = 2;
   localparam int P_PULSE = 12;
   localparam int P_GAP   = 50;
   localparam int P_CMD   = 2000;
   localparam int P_CLEAR = 8200;   // shortened clear/home wait keeps the run brief

   logic clk = 1'b0;
   logic reset;
   logic init_done;
   logic [3:0] SF_D;
   logic LCD_E, LCD_RS, LCD_RW;

   lcd_char_writer_if bif ();

   lcd_char_writer #(
      .C_SETUP      (P_SETUP),
      .C_PULSE      (P_PULSE),
      .C_NIBBLE_GAP (P_GAP),
      .C_CMD_WAIT   (P_CMD),
      .C_CLEAR_WAIT (P_CLEAR),
      .CNT_W        (20)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .init_done (init_done),
      .bus       (bif),
      .SF_D      (SF_D),
      .LCD_E     (LCD_E),
      .LCD_RS    (LCD_RS),
      .LCD_RW    (LCD_RW)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc_cyc = 0;

   // model state
   bit       m_busy = 1'b0;
   int       m_k    = 0;
   bit       m_rs_l = 1'b0;
   bit [7:0] m_data = 8'h00;
   int       m_wait = 0;
   bit       m_e = 1'b0, m_rs = 1'b0, m_done = 1'b0;
   bit [3:0] m_sf = 4'h0;

   logic [4:0] cap[$];
   logic       prev_e = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit is_slow(input bit rs, input bit [7:0] d);
      return (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
   endfunction

   function automatic int exp_lat(input bit rs, input bit [7:0] d);
      return 2*P_SETUP + 2*P_PULSE + P_GAP + (is_slow(rs, d) ? P_CLEAR : P_CMD) + 1;
   endfunction

   // Advance the model across one rising edge using the pre-edge inputs.
   task automatic model_step();
      int hi_end, lo_e_start, lo_e_end;
      hi_end     = P_SETUP + P_PULSE + P_GAP;
      lo_e_start = hi_end + P_SETUP;
      lo_e_end   = lo_e_start + P_PULSE;
      m_done = 1'b0;
      if (reset) begin
         m_busy = 1'b0; m_e = 1'b0; m_sf = 4'h0; m_rs = 1'b0;
      end else if (m_busy) begin
         m_k++;
         if (m_k > lo_e_end + m_wait) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_e    = 1'b0;
         end else begin
            m_e  = (m_k > P_SETUP && m_k <= P_SETUP + P_PULSE) ||
                   (m_k > lo_e_start && m_k <= lo_e_end);
            m_sf = (m_k <= hi_end) ? m_data[7:4] : m_data[3:0];
         end
      end else if (bif.in_valid && init_done) begin
         m_busy = 1'b1;
         m_k    = 1;
         m_data = bif.in_data;
         m_rs_l = bif.in_rs;
         m_wait = is_slow(bif.in_rs, bif.in_data) ? P_CLEAR : P_CMD;
         m_rs   = bif.in_rs;
         m_sf   = bif.in_data[7:4];
         m_e    = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("SF_D",     {28'd0, SF_D},   {28'd0, m_sf});
      chk("LCD_E",    {31'd0, LCD_E},  {31'd0, m_e});
      chk("LCD_RS",   {31'd0, LCD_RS}, {31'd0, m_rs});
      chk("LCD_RW",   {31'd0, LCD_RW}, 32'd0);
      chk("done",     {31'd0, bif.done}, {31'd0, m_done});
      chk("in_ready", {31'd0, bif.in_ready},
          {31'd0, (!m_busy && init_done && !reset)});
      if (LCD_E === 1'b1 && prev_e !== 1'b1) cap.push_back({LCD_RS, SF_D});
      prev_e = LCD_E;
   endtask

   // Present a byte and take the accepting edge.
   task automatic accept(input bit rs, input bit [7:0] d, input bit keep_valid);
      bif.in_valid = 1'b1;
      bif.in_rs    = rs;
      bif.in_data  = d;
      #1;
      chk("accept_ready", {31'd0, bif.in_ready}, 32'd1);
      tick();
      acc_cyc = cyc;
      if (!keep_valid) begin
         bif.in_valid = 1'b0;
         bif.in_data  = ~d;       // later input changes must not matter
         bif.in_rs    = ~rs;
      end
   endtask

   task automatic wait_done(input string tag, input int exp);
      while (bif.done !== 1'b1 && (cyc - acc_cyc) < exp + 20) tick();
      chk(tag, cyc - acc_cyc + 1, exp);
   endtask

   task automatic check_cap(input string tag, input bit rs, input bit [7:0] d);
      chk({tag, "_npulse"}, cap.size(), 2);
      if (cap.size() >= 2) begin
         chk({tag, "_hi"}, {27'd0, cap[0]}, {27'd0, rs, d[7:4]});
         chk({tag, "_lo"}, {27'd0, cap[1]}, {27'd0, rs, d[3:0]});
      end
   endtask

   task automatic send(input string tag, input bit rs, input bit [7:0] d);
      cap.delete();
      accept(rs, d, 1'b0);
      wait_done({tag, "_lat"}, exp_lat(rs, d));
      check_cap(tag, rs, d);
   endtask

   initial begin
      bit       r_rs;
      bit [7:0] r_d;
      reset        = 1'b1;
      init_done    = 1'b1;
      bif.in_valid = 1'b1;
      bif.in_rs    = 1'b1;
      bif.in_data  = 8'hA5;

      // reset held with in_valid high: everything quiet
      repeat (3) tick();
      reset        = 1'b0;
      bif.in_valid = 1'b0;
      tick();

      // plain data byte
      send("data41", 1'b1, 8'h41);
      chk("lat_normal_value", exp_lat(1'b1, 8'h41), 2079);

      // clear command uses the long wait; the same byte as data does not
      send("clear01", 1'b0, 8'h01);
      send("home02",  1'b0, 8'h02);
      send("data01",  1'b1, 8'h01);
      send("cmd04",   1'b0, 8'h04);

      // back-to-back with in_valid held and data changed mid-transfer
      cap.delete();
      accept(1'b1, 8'h48, 1'b1);
      bif.in_data = 8'h49;
      wait_done("b2b_first_lat", exp_lat(1'b1, 8'h48));
      chk("b2b_ready_at_done", {31'd0, bif.in_ready}, 32'd1);
      tick();
      acc_cyc = cyc;
      bif.in_valid = 1'b0;
      bif.in_data  = 8'h00;
      chk("b2b_second_sfd", {28'd0, SF_D}, 32'h4);
      wait_done("b2b_second_lat", exp_lat(1'b1, 8'h49));
      chk("b2b_npulse", cap.size(), 4);
      if (cap.size() == 4)
         chk("b2b_stream", {12'd0, cap[0][3:0], cap[1][3:0], cap[2][3:0], cap[3][3:0]},
             32'h4849);

      // init_done low blocks accepts
      cap.delete();
      init_done    = 1'b0;
      bif.in_valid = 1'b1;
      repeat (20) tick();
      chk("gated_no_pulse", cap.size(), 0);
      bif.in_valid = 1'b0;
      init_done    = 1'b1;
      tick();

      // init_done dropping during GAP does not stop the byte
      cap.delete();
      accept(1'b1, 8'h7E, 1'b0);
      while (cyc - acc_cyc + 1 < P_SETUP + P_PULSE + 5) tick();
      init_done = 1'b0;
      wait_done("gapdrop_lat", exp_lat(1'b1, 8'h7E));
      check_cap("gapdrop", 1'b1, 8'h7E);
      init_done = 1'b1;
      tick();

      // reset during the first LO_PULSE cycle abandons the byte
      cap.delete();
      accept(1'b1, 8'h5A, 1'b0);
      while (cyc - acc_cyc + 1 < 2*P_SETUP + P_PULSE + P_GAP + 1) tick();
      chk("lo_pulse_e_high", {31'd0, LCD_E}, 32'd1);
      reset = 1'b1;
      tick();
      chk("reset_e_low", {31'd0, LCD_E}, 32'd0);
      reset = 1'b0;
      tick();
      chk("post_reset_ready", {31'd0, bif.in_ready}, 32'd1);
      repeat (exp_lat(1'b1, 8'h5A)) tick();   // model demands done=0 throughout
      send("after_reset", 1'b1, 8'h33);

      // randomized bytes, occasionally biased toward slow commands
      for (int i = 0; i < 12; i++) begin
         r_rs = 1'($urandom_range(0, 1));
         r_d  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            r_rs = 1'b0;
            r_d  = 8'($urandom_range(0, 4));
         end
         repeat ($urandom_range(0, 3)) begin
            bif.in_data = 8'($urandom);
            tick();
         end
         send("rand", r_rs, r_d);
      end

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
